// File: rtl/pc_sequencer_if.sv
// Fetch/decode bus of the PC sequencer: instruction-memory req/ack handshake plus decode decision inputs.
// The master side is the sequencer; the slave side is the memory/decode environment.
interface pc_sequencer_if #(
  parameter int AW = 8,
  parameter int IW = 9
);
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_ack_i;
  logic [IW-1:0] imem_data_i;
  logic [IW-1:0] instr_o;
  logic          instr_valid_o;
  logic          stall_i;
  logic          branchf_i;
  logic          branchb_i;
  logic [AW-1:0] target_i;
  logic          halt_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, instr_valid_o,
    input  imem_ack_i, imem_data_i, stall_i, branchf_i, branchb_i, target_i, halt_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, instr_valid_o,
    output imem_ack_i, imem_data_i, stall_i, branchf_i, branchb_i, target_i, halt_i
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC/HALT controller driving instruction fetch and PC update.
// Optional retired-instruction counter enabled by defining PC_SEQ_ICOUNT_EN.
module pc_sequencer #(
  parameter int AW            = 8,
  parameter int IW            = 9,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] startadd_i,
  pc_sequencer_if.master bus,
  output logic [AW-1:0] pc_o,
  output logic [1:0]    state_o,
  output logic          done_o,
  output logic          error_o,
  output logic [15:0]   icount_o
);

  localparam int CW = $clog2(FETCH_TIMEOUT) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          req_q, req_d;
  logic          vld_q, vld_d;
  logic          done_q, done_d;

  // PC-relative target, modulo 2^AW; forward wins over backward.
  function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] pc,
                                            input logic          fwd,
                                            input logic          bwd,
                                            input logic [AW-1:0] off);
    logic [AW-1:0] inc;
    inc = pc + AW'(1);
    if (fwd)      return inc + off;
    else if (bwd) return inc - off;
    else          return inc;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    if (start_i) begin
      state_d = S_FETCH;
      pc_d    = startadd_i;
      err_d   = 1'b0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ack_i) begin
            instr_d = bus.imem_data_i;
            state_d = S_EXEC;
            tmo_d   = '0;
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_HALT;
            err_d   = 1'b1;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
        S_EXEC: begin
          // Decode's decision is only sampled once it stops stalling.
          if (!bus.stall_i) begin
            if (bus.halt_i) begin
              state_d = S_HALT;
            end else begin
              pc_d    = next_pc(pc_q, bus.branchf_i, bus.branchb_i, bus.target_i);
              state_d = S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
    // Output flags are registered from the next state so they line up with state_q.
    req_d  = (state_d == S_FETCH);
    vld_d  = (state_d == S_EXEC);
    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

`ifdef PC_SEQ_ICOUNT_EN
  logic [15:0] icount_q, icount_d;
  logic        retire;

  // Halt counts as a retirement; a start abandons the current instruction uncounted.
  assign retire = (state_q == S_EXEC) && !bus.stall_i && !start_i;

  always_comb begin
    icount_d = icount_q;
    if (start_i)     icount_d = '0;
    else if (retire) icount_d = icount_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) icount_q <= '0;
    else       icount_q <= icount_d;
  end

  assign icount_o = icount_q;
`else
  assign icount_o = '0;
`endif

  assign bus.imem_req_o    = req_q;
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_valid_o = vld_q;
  assign pc_o              = pc_q;
  assign state_o           = state_q;
  assign done_o            = done_q;
  assign error_o           = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver issues randomized fetch/decode traffic and pushes expected
// fetch, instruction and halt events; a monitor pops and compares them as the DUT presents each event.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam int AW = 8;
  localparam int IW = 9;
  localparam int FT = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] startadd_i = '0;
  logic [AW-1:0] pc_o;
  logic [1:0]    state_o;
  logic          done_o;
  logic          error_o;
  logic [15:0]   icount_o;

  pc_sequencer_if #(.AW(AW), .IW(IW)) bus ();

  pc_sequencer #(.AW(AW), .IW(IW), .FETCH_TIMEOUT(FT)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .startadd_i (startadd_i),
    .bus        (bus),
    .pc_o       (pc_o),
    .state_o    (state_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .icount_o   (icount_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] icnt;
    logic        err;
  } ev_t;

  ev_t           fetch_q[$];
  ev_t           halt_q[$];
  logic [IW-1:0] instr_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state (architectural view only)
  logic [7:0]    m_pc;
  logic [15:0]   m_icount;
  logic [IW-1:0] m_instr;
  bit            m_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_icnt();
`ifdef PC_SEQ_ICOUNT_EN
    return m_icount;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [7:0] ref_next(input int pc, input bit bf, input bit bb, input int t);
    int n;
    n = pc + 1;
    if (bf)      n = n + t;
    else if (bb) n = n - t;
    n = ((n % 256) + 256) % 256;
    return 8'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] a, input bit with_ack);
    start_i          = 1'b1;
    startadd_i       = a;
    bus.imem_ack_i   = with_ack;
    bus.imem_data_i  = IW'($urandom);
    m_pc     = a;
    m_icount = 16'd0;
    m_halted = 1'b0;
    fetch_q.push_back(ev_t'{addr: a, icnt: exp_icnt(), err: 1'b0});
    tick();
    start_i        = 1'b0;
    bus.imem_ack_i = 1'b0;
  endtask

  task automatic fetch(input int delay);
    logic [IW-1:0] d;
    bus.imem_ack_i = 1'b0;
    repeat (delay) tick();
    d = IW'($urandom);
    bus.imem_data_i = d;
    bus.imem_ack_i  = 1'b1;
    instr_q.push_back(d);
    m_instr = d;
    tick();
    bus.imem_ack_i  = 1'b0;
    bus.imem_data_i = IW'($urandom);
    check("ack_to_valid", bus.instr_valid_o, 1);
  endtask

  task automatic exec(input int stalls, input bit bf, input bit bb, input logic [7:0] t, input bit h);
    repeat (stalls) begin
      bus.stall_i   = 1'b1;
      bus.branchf_i = 1'b1;
      bus.branchb_i = 1'($urandom);
      bus.halt_i    = 1'($urandom);
      bus.target_i  = AW'($urandom);
      tick();
      check("stall_pc_held", pc_o, m_pc);
      check("stall_valid_high", bus.instr_valid_o, 1);
    end
    bus.stall_i   = 1'b0;
    bus.branchf_i = bf;
    bus.branchb_i = bb;
    bus.target_i  = t;
    bus.halt_i    = h;
    m_icount++;
    if (h) begin
      halt_q.push_back(ev_t'{addr: m_pc, icnt: exp_icnt(), err: 1'b0});
      m_halted = 1'b1;
    end else begin
      m_pc = ref_next(m_pc, bf, bb, t);
      fetch_q.push_back(ev_t'{addr: m_pc, icnt: exp_icnt(), err: 1'b0});
    end
    tick();
    bus.branchf_i = 1'b0;
    bus.branchb_i = 1'b0;
    bus.halt_i    = 1'b0;
    bus.target_i  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_pc"}, pc_o, 0);
    check({tag, "_addr"}, bus.imem_addr_o, 0);
    check({tag, "_instr"}, bus.instr_o, 0);
    check({tag, "_req"}, bus.imem_req_o, 0);
    check({tag, "_valid"}, bus.instr_valid_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_error"}, error_o, 0);
    check({tag, "_icount"}, icount_o, 0);
  endtask

  // Monitor: pops an expectation whenever the DUT starts a fetch, presents an instruction or enters HALT.
  logic       mon_req_p = 1'b0;
  logic       mon_vld_p = 1'b0;
  logic [1:0] mon_st_p  = 2'd0;

  initial begin : monitor
    logic          st_e;
    logic          rs_e;
    ev_t           e;
    logic [IW-1:0] ei;
    forever begin
      @(posedge clk);
      st_e = start_i;
      rs_e = rst_i;
      #1;
      if (!rs_e) begin
        if (bus.imem_req_o && (!mon_req_p || st_e)) begin
          check("fetch_expected", fetch_q.size() > 0, 1);
          if (fetch_q.size() > 0) begin
            e = fetch_q.pop_front();
            check("fetch_addr", bus.imem_addr_o, e.addr);
            check("fetch_pc", pc_o, e.addr);
            check("fetch_state", state_o, 1);
            check("fetch_error", error_o, e.err);
            check("fetch_icount", icount_o, e.icnt);
          end
        end
        if (bus.instr_valid_o && !mon_vld_p) begin
          check("instr_expected", instr_q.size() > 0, 1);
          if (instr_q.size() > 0) begin
            ei = instr_q.pop_front();
            check("instr_data", bus.instr_o, ei);
            check("instr_state", state_o, 2);
            check("instr_no_req", bus.imem_req_o, 0);
          end
        end
        if (state_o == 2'd3 && mon_st_p != 2'd3) begin
          check("halt_expected", halt_q.size() > 0, 1);
          if (halt_q.size() > 0) begin
            e = halt_q.pop_front();
            check("halt_pc", pc_o, e.addr);
            check("halt_error", error_o, e.err);
            check("halt_done", done_o, 1);
            check("halt_no_req", bus.imem_req_o, 0);
            check("halt_icount", icount_o, e.icnt);
          end
        end
      end
      mon_req_p = bus.imem_req_o;
      mon_vld_p = bus.instr_valid_o;
      mon_st_p  = state_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int cnt;
    int d;
    bit bf, bb, h;
    bus.imem_ack_i  = 1'b0;
    bus.imem_data_i = '0;
    bus.stall_i     = 1'b0;
    bus.branchf_i   = 1'b0;
    bus.branchb_i   = 1'b0;
    bus.target_i    = '0;
    bus.halt_i      = 1'b0;
    m_pc = 8'h00; m_icount = 16'd0; m_instr = '0; m_halted = 1'b1;

    // Reset values, then IDLE ignores acks
    rst_i = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst_i = 1'b0;
    bus.imem_ack_i  = 1'b1;
    bus.imem_data_i = 9'h1FF;
    tick(); tick();
    bus.imem_ack_i = 1'b0;
    check("idle_req", bus.imem_req_o, 0);
    check("idle_instr", bus.instr_o, 0);
    check("idle_state", state_o, 0);

    // Sequential fetch from 0x10
    do_start(8'h10, 1'b0);
    repeat (3) begin fetch(0); exec(0, 0, 0, 8'h00, 0); end

    // Forward, backward, both-high branches
    do_start(8'h20, 1'b0);
    fetch(0); exec(0, 1, 0, 8'h05, 0);
    fetch(1); exec(0, 0, 1, 8'h10, 0);
    fetch(0); exec(0, 1, 1, 8'h03, 0);

    // Wrap-around, and an ack on the last cycle before timeout
    do_start(8'hFF, 1'b0);
    fetch(0); exec(0, 0, 0, 8'h00, 0);
    do_start(8'h02, 1'b0);
    fetch(FT - 1); exec(0, 0, 1, 8'h05, 0);

    // Fetch timeout
    do_start(8'h40, 1'b0);
    halt_q.push_back(ev_t'{addr: 8'h40, icnt: exp_icnt(), err: 1'b1});
    m_halted = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && state_o != 2'd3; i++) begin
      if (bus.imem_req_o) cnt++;
      tick();
    end
    check("timeout_req_cycles", cnt, FT);
    check("timeout_state", state_o, 3);
    check("timeout_done", done_o, 1);
    check("timeout_error", error_o, 1);
    bus.imem_ack_i  = 1'b1;
    bus.imem_data_i = ~m_instr;
    tick(); tick();
    bus.imem_ack_i = 1'b0;
    check("halt_ack_valid", bus.instr_valid_o, 0);
    check("halt_ack_instr", bus.instr_o, m_instr);
    check("halt_ack_state", state_o, 3);
    do_start(8'h41, 1'b0);
    check("restart_error_cleared", error_o, 0);

    // Stall with branch inputs active, then release
    fetch(0); exec(3, 1, 0, 8'h04, 0);

    // Halt beats branch
    fetch(0); exec(0, 1, 0, 8'h07, 1);

    // Start mid-FETCH with a simultaneous ack
    do_start(8'h50, 1'b0);
    do_start(8'h60, 1'b1);
    check("start_ack_valid", bus.instr_valid_o, 0);
    check("start_ack_state", state_o, 1);
    fetch(0); exec(0, 0, 0, 8'h00, 0);

    // Reset mid-EXEC
    fetch(0);
    rst_i = 1'b1;
    tick();
    check_reset_values("rst_exec");
    rst_i = 1'b0;
    m_icount = 16'd0; m_halted = 1'b1;
    tick();

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      if (m_halted || $urandom_range(0, 9) == 0)
        do_start(8'($urandom), 1'b0);
      d = ($urandom_range(0, 7) == 0) ? FT - 1 : int'($urandom_range(0, 2));
      fetch(d);
      bf = ($urandom_range(0, 2) == 0);
      bb = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 7) == 0);
      exec(int'($urandom_range(0, 2)), bf, bb, 8'($urandom), h);
    end

    tick(); tick();
    check("fetch_q_drained", fetch_q.size(), 0);
    check("instr_q_drained", instr_q.size(), 0);
    check("halt_q_drained", halt_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter controller that sequences instruction fetch for the single-cycle core.
- Holds the architectural PC and issues fetch requests to instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode, then applies decode's branch/halt decision to form the next PC (start load, PC-relative forward/backward branch, or increment).
- Sits between the instruction memory and the decode/branch unit.

Parameters:
- AW, 8, PC/address width; all PC arithmetic is modulo 2^AW.
- IW, 9, instruction word width.
- FETCH_TIMEOUT, 16, maximum cycles waiting for imem_ack_i before error halt (≥1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  restart pulse; load PC from startadd_i.
- startadd_i  in  AW  program start address.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  AW  fetch address (= pc_o).
- imem_ack_i  in  1  fetch data valid.
- imem_data_i  in  IW  fetched instruction.
- instr_o  out  IW  latched instruction for decode.
- instr_valid_o  out  1  instr_o is valid and awaiting decision.
- stall_i  in  1  decode not ready; hold in EXEC.
- branchf_i  in  1  forward branch taken.
- branchb_i  in  1  backward branch taken.
- target_i  in  AW  unsigned branch offset, PC-relative.
- halt_i  in  1  current instruction is halt.
- pc_o  out  AW  current PC.
- state_o  out  2  IDLE=0, FETCH=1, EXEC=2, HALT=3.
- done_o  out  1  high in HALT.
- error_o  out  1  sticky fetch-timeout flag.
- icount_o  out  16  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (rst_i=1 at edge):
  - state=IDLE, pc_o=0, instr_o=0, all flags 0, timeout counter 0, icount_o=0.
  - Reset has priority over all inputs, including mid-fetch; the request drops on the next cycle.
- start_i: honoured in every state and has priority over everything except reset.
  - pc_o ← startadd_i, state ← FETCH, error_o ← 0, timeout counter ← 0.
  - Any in-flight fetch is abandoned; an ack arriving in that same cycle is ignored.
- IDLE: outputs quiescent; waits for start_i.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc_o; request held until acked.
  - imem_ack_i=1: instr_o ← imem_data_i, state ← EXEC, counter ← 0.
  - Otherwise the counter increments. When the counter reaches FETCH_TIMEOUT-1 with no ack: state ← HALT, error_o ← 1.
- EXEC:
  - instr_valid_o=1, imem_req_o=0.
  - stall_i=1: hold everything; ignore branch and halt inputs.
  - Otherwise, if halt_i=1: state ← HALT, PC unchanged. halt_i has priority over branches.
  - Otherwise pc_o ← next PC, state ← FETCH, where next PC is:
    - branchf_i: pc+1+target_i
    - else branchb_i: pc+1−target_i
    - else: pc+1
  - branchf_i wins when both branch inputs are high.
  - Arithmetic is AW bits and wraps: 8'hFF+1 → 8'h00; 8'h02+1−8'h05 → 8'hFE.
- HALT: done_o=1, imem_req_o=0, instr_valid_o=0; leaves only on start_i or reset.
- Ack outside FETCH is ignored.
- Latency:
  - start → first imem_req_o: 1 cycle.
  - Ack → instr_valid_o: 1 cycle.
  - Minimum instruction period: 2 cycles (FETCH with same-cycle ack, then EXEC).

Optional Feature:
- Macro PC_SEQ_ICOUNT_EN.
- When defined: icount_o increments by 1 (wrapping at 16 bits) on each EXEC exit to FETCH or HALT.
  - Halt counts as retired.
  - Stalled cycles do not count.
  - Cleared by reset and by start_i.
- When undefined: no counter logic; icount_o tied to 0.

Test Plan:
- Reset, then start_i with startadd_i=8'h10, memory acking immediately, no branches → imem_addr_o sequence 10,11,12; instr_valid_o pulses once per 2 cycles; state_o alternates 1/2.
- At pc=8'h20: branchf_i=1, target_i=8'h05 → next fetch address 8'h26. At pc=8'h26: branchb_i=1, target_i=8'h10 → 8'h17. Both branch inputs high with target 3 at pc 8'h17 → 8'h1B.
- Wrap: start at 8'hFF, no branch → next fetch 8'h00. At pc=8'h02, branchb_i with target 5 → 8'hFE.
- Memory never acks, FETCH_TIMEOUT=16 → exactly 16 cycles of imem_req_o, then state_o=3, done_o=1, error_o=1. A following start_i clears error_o and resumes FETCH.
- In EXEC, hold stall_i=1 for 3 cycles with branchf_i=1 → PC unchanged, instr_valid_o high throughout. Release stall → branch applied once. With PC_SEQ_ICOUNT_EN, icount_o rises by exactly 1.
- halt_i with branchf_i in the same EXEC cycle → HALT, PC unchanged. start_i asserted mid-FETCH with a simultaneous ack → ack ignored; fetch restarts at startadd_i. rst_i mid-EXEC → all outputs at reset values next cycle.
